store_checker: RTL and testbench

- Synthesizable self-check monitor for RV32I core runs: watches the data-memory store bus (mem_write, data_adr, write_data) and issues pass/fail/timeout verdicts.
- Checks stores against a runtime-programmable checkpoint table and a terminal "success" store.
- Generalises the fixed single-checkpoint bench check: configurable depth, ordered mode, strict data mode, and a watchdog.
- Sits beside the core's top, on the same clock; used both in simulation and in FPGA bring-up (verdict drives LEDs).

---
 rtl/store_check_pkg.sv | 25 ++
 rtl/checkpoint_table.sv | 60 ++++++
 rtl/store_checker.sv | 210 +++++++++++++++++++++
 tb/tb_store_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_check_pkg.sv
// Shared types for the RV32I store-bus self-check monitor.
// Holds the FSM state encoding, the per-store verdict encoding and index-width helper.
package store_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TOUT
  } state_t;

  typedef enum logic [1:0] {
    V_NONE,
    V_PASS,
    V_FAIL,
    V_TOUT
  } verdict_t;

  // A single-entry table still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/checkpoint_table.sv
// Programmable checkpoint table: per-entry enable/address/data registers and
// a combinational lowest-index address match against the current store.
module checkpoint_table
  import store_check_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NUM_CHECKS = 4,
  localparam int IDX_W      = idx_width(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_en,
  input  logic [XLEN-1:0]       cfg_adr,
  input  logic [XLEN-1:0]       cfg_data,
  input  logic [XLEN-1:0]       data_adr,
  input  logic [XLEN-1:0]       write_data,
  output logic [NUM_CHECKS-1:0] en_mask,
  output logic                  match,
  output logic [IDX_W-1:0]      match_idx,
  output logic                  data_ok
);

  logic [XLEN-1:0] adr_q  [NUM_CHECKS];
  logic [XLEN-1:0] data_q [NUM_CHECKS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_mask <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          en_mask[i] <= cfg_en;
          adr_q[i]   <= cfg_adr;
          data_q[i]  <= cfg_data;
        end
      end
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    data_ok   = 1'b0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (en_mask[i] && (adr_q[i] == data_adr)) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
        data_ok   = (data_q[i] == write_data);
      end
    end
  end

endmodule

// File: rtl/store_checker.sv
// Store-bus self-check monitor: evaluates core stores against the checkpoint table
// and a terminal success store, and issues sticky pass/fail/timeout verdicts.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | evaluating stores, watchdog counting
// PASS  | terminal store seen with all required checkpoints hit
// FAIL  | offending store latched in fail_adr/fail_data
// TOUT  | watchdog expired without a verdict
module store_checker
  import store_check_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int NUM_CHECKS     = 4,
  parameter  int ORDERED        = 0,
  parameter  int STRICT         = 0,
  parameter  int REQUIRE_ALL    = 1,
  parameter  int TIMEOUT_CYCLES = 4096,
  parameter  int CNT_W          = 8,
  localparam int IDX_W          = idx_width(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_en,
  input  logic [XLEN-1:0]       cfg_adr,
  input  logic [XLEN-1:0]       cfg_data,
  input  logic [XLEN-1:0]       term_adr,
  input  logic [XLEN-1:0]       term_data,
  input  logic                  mem_write,
  input  logic [XLEN-1:0]       data_adr,
  input  logic [XLEN-1:0]       write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic                  cp_hit,
  output logic [IDX_W-1:0]      cp_idx,
  output logic [NUM_CHECKS-1:0] hit_mask,
  output logic [CNT_W-1:0]      mismatch_cnt,
  output logic [CNT_W-1:0]      store_cnt,
  output logic [XLEN-1:0]       fail_adr,
  output logic [XLEN-1:0]       fail_data
);

  localparam int               PTR_W   = IDX_W + 1;
  localparam int               WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t   state, state_nx;
  verdict_t verdict;

  logic [NUM_CHECKS-1:0] en_mask;
  logic                  match;
  logic [IDX_W-1:0]      match_idx;
  logic                  data_ok;

  logic [WD_W-1:0]  wd_cnt;
  logic [PTR_W-1:0] ord_ptr;
  logic [PTR_W-1:0] ptr_eff;
  logic             ptr_valid;
  logic             cfg_ok;
  logic             store_ev;
  logic             term_hit;
  logic             all_hit;
  logic             order_ok;
  logic             hit_ev;
  logic             miss_data;
  logic             wd_exp;

  assign cfg_ok = cfg_we && (state != RUN);

  checkpoint_table #(
    .XLEN       (XLEN),
    .NUM_CHECKS (NUM_CHECKS)
  ) u_table (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we     (cfg_ok),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_adr    (cfg_adr),
    .cfg_data   (cfg_data),
    .data_adr   (data_adr),
    .write_data (write_data),
    .en_mask    (en_mask),
    .match      (match),
    .match_idx  (match_idx),
    .data_ok    (data_ok)
  );

  // The pointer only records "next index at or above"; disabled entries are skipped here.
  always_comb begin
    ptr_valid = 1'b0;
    ptr_eff   = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (en_mask[i] && (PTR_W'(i) >= ord_ptr)) begin
        ptr_valid = 1'b1;
        ptr_eff   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    store_ev  = (state == RUN) && mem_write && !start;
    term_hit  = (data_adr == term_adr) && (write_data == term_data);
    all_hit   = ((hit_mask & en_mask) == en_mask);
    order_ok  = (ORDERED == 0) || (ptr_valid && (ptr_eff == {1'b0, match_idx}));
    hit_ev    = store_ev && !term_hit && match && data_ok && order_ok;
    miss_data = store_ev && !term_hit && match && !data_ok;
    wd_exp    = (TIMEOUT_CYCLES != 0) && (state == RUN) && !start && (wd_cnt == WD_LAST);

    verdict = V_NONE;
    if (store_ev) begin
      if (term_hit) begin
        verdict = ((REQUIRE_ALL != 0) && !all_hit) ? V_FAIL : V_PASS;
      end else if (!match) begin
        verdict = V_FAIL;
      end else if (data_ok && !order_ok) begin
        verdict = V_FAIL;
      end else if (!data_ok && (STRICT != 0)) begin
        verdict = V_FAIL;
      end
    end
    // A store verdict on the expiry cycle wins over the watchdog.
    if ((verdict == V_NONE) && wd_exp) begin
      verdict = V_TOUT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, PASS, FAIL, TOUT: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (start) begin
          state_nx = RUN;
        end else begin
          case (verdict)
            V_PASS:  state_nx = PASS;
            V_FAIL:  state_nx = FAIL;
            V_TOUT:  state_nx = TOUT;
            default: state_nx = RUN;
          endcase
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cp_hit       <= 1'b0;
      cp_idx       <= '0;
      hit_mask     <= '0;
      mismatch_cnt <= '0;
      store_cnt    <= '0;
      fail_adr     <= '0;
      fail_data    <= '0;
      wd_cnt       <= '0;
      ord_ptr      <= '0;
    end else begin
      cp_hit <= 1'b0;
      if (start) begin
        hit_mask     <= '0;
        mismatch_cnt <= '0;
        store_cnt    <= '0;
        fail_adr     <= '0;
        fail_data    <= '0;
        wd_cnt       <= '0;
        ord_ptr      <= '0;
      end else if (state == RUN) begin
        wd_cnt <= wd_cnt + WD_W'(1);
        if (store_ev && (store_cnt != '1)) begin
          store_cnt <= store_cnt + CNT_W'(1);
        end
        if (hit_ev) begin
          hit_mask[match_idx] <= 1'b1;
          cp_hit              <= 1'b1;
          cp_idx              <= match_idx;
          ord_ptr             <= {1'b0, match_idx} + PTR_W'(1);
        end
        if (miss_data && (mismatch_cnt != '1)) begin
          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
        if (verdict == V_FAIL) begin
          fail_adr  <= data_adr;
          fail_data <= write_data;
        end
      end
    end
  end

  assign busy    = (state == RUN);
  assign pass    = (state == PASS);
  assign fail    = (state == FAIL);
  assign timeout = (state == TOUT);
  assign done    = pass || fail || timeout;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: three instances share stimulus and differ in
// mode (relaxed with short watchdog, strict data, ordered checkpoints).
module tb_store_checker;

  logic        clk, reset_n, start, cfg_we, cfg_en, mem_write;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_adr, cfg_data, term_adr, term_data, data_adr, write_data;

  logic        busy_a, done_a, pass_a, fail_a, tout_a, cp_hit_a;
  logic [1:0]  cp_idx_a;
  logic [3:0]  hit_a;
  logic [7:0]  mis_a, st_a;
  logic [31:0] fadr_a, fdat_a;

  logic        busy_s, done_s, pass_s, fail_s, tout_s, cp_hit_s;
  logic [1:0]  cp_idx_s;
  logic [3:0]  hit_s;
  logic [7:0]  mis_s, st_s;
  logic [31:0] fadr_s, fdat_s;

  logic        busy_o, done_o, pass_o, fail_o, tout_o, cp_hit_o;
  logic [1:0]  cp_idx_o;
  logic [3:0]  hit_o;
  logic [7:0]  mis_o, st_o;
  logic [31:0] fadr_o, fdat_o;

  int checks = 0;
  int passed = 0;

  store_checker #(.ORDERED(0), .STRICT(0), .REQUIRE_ALL(1), .TIMEOUT_CYCLES(16)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_adr(cfg_adr), .cfg_data(cfg_data), .term_adr(term_adr),
    .term_data(term_data), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(tout_a),
    .cp_hit(cp_hit_a), .cp_idx(cp_idx_a), .hit_mask(hit_a), .mismatch_cnt(mis_a),
    .store_cnt(st_a), .fail_adr(fadr_a), .fail_data(fdat_a)
  );

  store_checker #(.ORDERED(0), .STRICT(1), .REQUIRE_ALL(1), .TIMEOUT_CYCLES(0)) u_s (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_adr(cfg_adr), .cfg_data(cfg_data), .term_adr(term_adr),
    .term_data(term_data), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail(fail_s), .timeout(tout_s),
    .cp_hit(cp_hit_s), .cp_idx(cp_idx_s), .hit_mask(hit_s), .mismatch_cnt(mis_s),
    .store_cnt(st_s), .fail_adr(fadr_s), .fail_data(fdat_s)
  );

  store_checker #(.ORDERED(1), .STRICT(0), .REQUIRE_ALL(1), .TIMEOUT_CYCLES(0)) u_o (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_adr(cfg_adr), .cfg_data(cfg_data), .term_adr(term_adr),
    .term_data(term_data), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .busy(busy_o), .done(done_o), .pass(pass_o), .fail(fail_o), .timeout(tout_o),
    .cp_hit(cp_hit_o), .cp_idx(cp_idx_o), .hit_mask(hit_o), .mismatch_cnt(mis_o),
    .store_cnt(st_o), .fail_adr(fadr_o), .fail_data(fdat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic cfg(input logic [1:0] idx, input logic en, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_adr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; data_adr = a; write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%0h want=0", busy_a); else passed++;
    checks++; if ({done_a, pass_a, fail_a, tout_a} !== 4'b0) $display("FAIL reset_verdict got=%0h want=0", {done_a, pass_a, fail_a, tout_a}); else passed++;
    checks++; if (hit_a !== 4'b0) $display("FAIL reset_hit_mask got=%0h want=0", hit_a); else passed++;
    checks++; if ({st_a, mis_a} !== 16'h0) $display("FAIL reset_counters got=%0h want=0", {st_a, mis_a}); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    cfg(2'd0, 1'b1, 32'd96, 32'd7);
    run();
    checks++; if (busy_a !== 1'b1) $display("FAIL basic_busy got=%0h want=1", busy_a); else passed++;
    store(32'd96, 32'd7);
    checks++; if (cp_hit_a !== 1'b1) $display("FAIL basic_cp_hit got=%0h want=1", cp_hit_a); else passed++;
    checks++; if (cp_idx_a !== 2'd0) $display("FAIL basic_cp_idx got=%0h want=0", cp_idx_a); else passed++;
    checks++; if (hit_a !== 4'b0001) $display("FAIL basic_hit_mask got=%0h want=1", hit_a); else passed++;
    store(32'd32, 32'd25);
    checks++; if (pass_a !== 1'b1) $display("FAIL basic_pass got=%0h want=1", pass_a); else passed++;
    checks++; if (done_a !== 1'b1) $display("FAIL basic_done got=%0h want=1", done_a); else passed++;
    checks++; if (st_a !== 8'd2) $display("FAIL basic_store_cnt got=%0d want=2", st_a); else passed++;
    checks++; if (cp_hit_a !== 1'b0) $display("FAIL basic_cp_hit_pulse got=%0h want=0", cp_hit_a); else passed++;
  endtask

  task automatic test_mismatch();
    do_reset();
    cfg(2'd0, 1'b1, 32'd96, 32'd7);
    run();
    store(32'd96, 32'd5);
    checks++; if (mis_a !== 8'd1) $display("FAIL mism_cnt got=%0d want=1", mis_a); else passed++;
    checks++; if (busy_a !== 1'b1) $display("FAIL mism_still_run got=%0h want=1", busy_a); else passed++;
    checks++; if (fail_s !== 1'b1) $display("FAIL mism_strict_fail got=%0h want=1", fail_s); else passed++;
    checks++; if (fadr_s !== 32'd96) $display("FAIL mism_strict_adr got=%0d want=96", fadr_s); else passed++;
    checks++; if (fdat_s !== 32'd5) $display("FAIL mism_strict_data got=%0d want=5", fdat_s); else passed++;
    store(32'd96, 32'd7);
    store(32'd32, 32'd25);
    checks++; if (pass_a !== 1'b1) $display("FAIL mism_pass got=%0h want=1", pass_a); else passed++;
    checks++; if (mis_a !== 8'd1) $display("FAIL mism_cnt_final got=%0d want=1", mis_a); else passed++;
    checks++; if (st_s !== 8'd1) $display("FAIL mism_strict_frozen got=%0d want=1", st_s); else passed++;
  endtask

  task automatic test_no_match();
    run();
    store(32'd100, 32'd1);
    checks++; if (fail_a !== 1'b1) $display("FAIL nomatch_fail got=%0h want=1", fail_a); else passed++;
    checks++; if (fadr_a !== 32'd100) $display("FAIL nomatch_adr got=%0d want=100", fadr_a); else passed++;
    store(32'd32, 32'd25);
    store(32'd96, 32'd7);
    checks++; if ({pass_a, fail_a, cp_hit_a} !== 3'b010) $display("FAIL nomatch_sticky got=%0h want=2", {pass_a, fail_a, cp_hit_a}); else passed++;
    checks++; if (st_a !== 8'd1) $display("FAIL nomatch_store_cnt got=%0d want=1", st_a); else passed++;
    checks++; if (fadr_a !== 32'd100) $display("FAIL nomatch_adr_held got=%0d want=100", fadr_a); else passed++;
  endtask

  task automatic test_ordered();
    do_reset();
    cfg(2'd0, 1'b1, 32'd96, 32'd7);
    cfg(2'd1, 1'b1, 32'd64, 32'd3);
    run();
    store(32'd64, 32'd3);
    checks++; if (fail_o !== 1'b1) $display("FAIL ord_out_of_order got=%0h want=1", fail_o); else passed++;
    checks++; if (fadr_o !== 32'd64) $display("FAIL ord_fail_adr got=%0d want=64", fadr_o); else passed++;
    run();
    store(32'd96, 32'd7);
    store(32'd64, 32'd3);
    checks++; if ({cp_hit_o, cp_idx_o} !== 3'b101) $display("FAIL ord_cp_idx got=%0h want=5", {cp_hit_o, cp_idx_o}); else passed++;
    store(32'd32, 32'd25);
    checks++; if (hit_o !== 4'b0011) $display("FAIL ord_hit_mask got=%0h want=3", hit_o); else passed++;
    checks++; if (pass_o !== 1'b1) $display("FAIL ord_pass got=%0h want=1", pass_o); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    run();
    store(32'd96, 32'd7);
    checks++; if (fail_a !== 1'b1) $display("FAIL tout_table_cleared got=%0h want=1", fail_a); else passed++;
    cfg(2'd0, 1'b1, 32'd96, 32'd7);
    run();
    n = 0;
    while (!tout_a && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 16) $display("FAIL tout_latency got=%0d want=16", n); else passed++;
    checks++; if ({busy_a, done_a, tout_a} !== 3'b011) $display("FAIL tout_state got=%0h want=3", {busy_a, done_a, tout_a}); else passed++;
    run();
    store(32'd96, 32'd7);
    tick();
    checks++; if ({busy_a, hit_a} !== 5'b10001) $display("FAIL tout_second_run got=%0h want=11", {busy_a, hit_a}); else passed++;
    reset_n = 1'b0;
    #1;
    checks++; if (busy_a !== 1'b0) $display("FAIL async_reset_busy got=%0h want=0", busy_a); else passed++;
    checks++; if ({done_a, hit_a, st_a} !== 13'h0) $display("FAIL async_reset_outputs got=%0h want=0", {done_a, hit_a, st_a}); else passed++;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_require_all();
    do_reset();
    cfg(2'd0, 1'b1, 32'd96, 32'd7);
    cfg(2'd1, 1'b1, 32'd64, 32'd3);
    run();
    store(32'd96, 32'd7);
    store(32'd32, 32'd25);
    checks++; if ({pass_a, fail_a} !== 2'b01) $display("FAIL reqall_fail got=%0h want=1", {pass_a, fail_a}); else passed++;
    checks++; if (fadr_a !== 32'd32) $display("FAIL reqall_fail_adr got=%0d want=32", fadr_a); else passed++;
    run();
    cfg(2'd1, 1'b0, 32'd0, 32'd0);
    store(32'd96, 32'd7);
    store(32'd32, 32'd25);
    checks++; if (fail_a !== 1'b1) $display("FAIL cfg_in_run_dropped got=%0h want=1", fail_a); else passed++;
    run();
    store(32'd96, 32'd7);
    store(32'd64, 32'd3);
    store(32'd32, 32'd25);
    checks++; if ({pass_a, hit_a} !== 5'b10011) $display("FAIL reqall_next_run got=%0h want=13", {pass_a, hit_a}); else passed++;
  endtask

  task automatic test_cfg_with_start();
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_en = 1'b1; cfg_adr = 32'd100; cfg_data = 32'd9;
    start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    checks++; if (busy_a !== 1'b1) $display("FAIL cfgstart_busy got=%0h want=1", busy_a); else passed++;
    store(32'd100, 32'd9);
    checks++; if ({cp_hit_a, cp_idx_a, busy_a} !== 4'b1101) $display("FAIL cfgstart_hit got=%0h want=d", {cp_hit_a, cp_idx_a, busy_a}); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    cfg(2'd0, 1'b1, 32'd96, 32'd7);
    run();
    mem_write = 1'b1; data_adr = 32'd96; write_data = 32'd7;
    repeat (300) tick();
    mem_write = 1'b0;
    checks++; if (st_s !== 8'hFF) $display("FAIL sat_store_cnt got=%0h want=ff", st_s); else passed++;
    checks++; if ({busy_s, hit_s} !== 5'b10001) $display("FAIL sat_run_state got=%0h want=11", {busy_s, hit_s}); else passed++;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_en = 1'b0; cfg_idx = 2'd0;
    cfg_adr = '0; cfg_data = '0; mem_write = 1'b0; data_adr = '0; write_data = '0;
    term_adr = 32'd32; term_data = 32'd25;
    #2;
    test_reset();
    test_basic();
    test_mismatch();
    test_no_match();
    test_ordered();
    test_timeout();
    test_require_all();
    test_cfg_with_start();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
